// File: rtl/plot_arbiter_if.sv
// Pixel-write port bundle between requesters, the clear control and the
// plot arbiter that owns the VGA adapter write port.
interface plot_arbiter_if;
    logic       clear_req;
    logic       req0;
    logic       req1;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic [2:0] c0;
    logic [2:0] c1;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       clear_busy;
    logic       clear_done;

    modport master (
        output clear_req, req0, req1, x0, x1, y0, y1, c0, c1,
        input  gnt0, gnt1, x, y, colour, plot, clear_busy, clear_done
    );

    modport slave (
        input  clear_req, req0, req1, x0, x1, y0, y1, c0, c1,
        output gnt0, gnt1, x, y, colour, plot, clear_busy, clear_done
    );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter for two pixel writers plus a full-frame clear sweep,
// driving a registered x/y/colour/plot port into the VGA adapter.
module plot_arbiter #(
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input logic           clk,
    input logic           reset,
    plot_arbiter_if.slave bus
);

    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [6:0] YM = 7'(Y_MAX);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t     state, state_n;
    logic [7:0] cx, cx_n;
    logic [6:0] cy, cy_n;
    logic       last, last_n;
    logic [7:0] x_q, x_n;
    logic [6:0] y_q, y_n;
    logic [2:0] col_q, col_n;
    logic       plot_q, plot_n;
    logic       g0_q, g0_n;
    logic       g1_q, g1_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       el0, el1;

    // A requester just granted is presenting its next pixel, so skip it once.
    assign el0 = bus.req0 & ~g0_q;
    assign el1 = bus.req1 & ~g1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cx     <= '0;
            cy     <= '0;
            last   <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
            plot_q <= 1'b0;
            g0_q   <= 1'b0;
            g1_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cx     <= cx_n;
            cy     <= cy_n;
            last   <= last_n;
            x_q    <= x_n;
            y_q    <= y_n;
            col_q  <= col_n;
            plot_q <= plot_n;
            g0_q   <= g0_n;
            g1_q   <= g1_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        last_n  = last;
        x_n     = x_q;
        y_n     = y_q;
        col_n   = col_q;
        plot_n  = 1'b0;
        g0_n    = 1'b0;
        g1_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_n = CLEAR;
                    cx_n    = '0;
                    cy_n    = '0;
                    x_n     = '0;
                    y_n     = '0;
                    col_n   = CLEAR_COLOUR;
                    plot_n  = 1'b1;
                    busy_n  = 1'b1;
                end else if (el0 && (!el1 || last)) begin
                    g0_n   = 1'b1;
                    plot_n = 1'b1;
                    x_n    = bus.x0;
                    y_n    = bus.y0;
                    col_n  = bus.c0;
                    last_n = 1'b0;
                end else if (el1) begin
                    g1_n   = 1'b1;
                    plot_n = 1'b1;
                    x_n    = bus.x1;
                    y_n    = bus.y1;
                    col_n  = bus.c1;
                    last_n = 1'b1;
                end
            end
            CLEAR: begin
                if (cx == XM && cy == YM) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    if (cx == XM) begin
                        cx_n = '0;
                        cy_n = cy + 7'd1;
                    end else begin
                        cx_n = cx + 8'd1;
                    end
                    x_n    = cx_n;
                    y_n    = cy_n;
                    col_n  = CLEAR_COLOUR;
                    plot_n = 1'b1;
                    busy_n = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.gnt0       = g0_q;
    assign bus.gnt1       = g1_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = col_q;
    assign bus.plot       = plot_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a pixel-level reference model queues
// the expected write port activity, a negedge monitor checks it.
module tb_plot_arbiter;

    localparam int XW   = 160;
    localparam int YH   = 120;
    localparam int NPIX = XW * YH;

    typedef struct {
        int         cyc;
        logic       plot;
        logic       g0;
        logic       g1;
        logic       busy;
        logic       done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    // reference model state: sweep pixel index (-1 when not sweeping)
    int m_pos  = -1;
    bit m_done = 0;
    bit m_last = 1;
    bit m_g0   = 0;
    bit m_g1   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    plot_arbiter_if bus ();

    plot_arbiter #(
        .X_MAX(159),
        .Y_MAX(119),
        .CLEAR_COLOUR(3'b000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic push_item(input bit p, g0, g1, busy, done,
                             input int px, py, pc);
        exp_t e;
        e.cyc  = cyc + 1;
        e.plot = p;
        e.g0   = g0;
        e.g1   = g1;
        e.busy = busy;
        e.done = done;
        e.x    = 8'(px);
        e.y    = 7'(py);
        e.c    = 3'(pc);
        q.push_back(e);
    endtask

    task automatic step(input bit rst, clr, r0, r1);
        bit e0, e1;
        int w;
        if (rst) begin
            m_pos = -1; m_done = 0; m_last = 1; m_g0 = 0; m_g1 = 0;
            return;
        end
        if (m_done) begin
            m_done = 0; m_g0 = 0; m_g1 = 0;
            return;
        end
        if (m_pos >= 0) begin
            if (m_pos == NPIX - 1) begin
                m_pos  = -1;
                m_done = 1;
                push_item(0, 0, 0, 0, 1, 0, 0, 0);
            end else begin
                m_pos++;
                push_item(1, 0, 0, 1, 0, m_pos % XW, m_pos / XW, 0);
            end
            m_g0 = 0; m_g1 = 0;
            return;
        end
        e0 = r0 && !m_g0;
        e1 = r1 && !m_g1;
        m_g0 = 0; m_g1 = 0;
        if (clr) begin
            m_pos = 0;
            push_item(1, 0, 0, 1, 0, 0, 0, 0);
            return;
        end
        w = -1;
        if (e0 && e1) w = m_last ? 0 : 1;
        else if (e0) w = 0;
        else if (e1) w = 1;
        if (w == 0) begin
            push_item(1, 1, 0, 0, 0, int'(bus.x0), int'(bus.y0), int'(bus.c0));
            m_g0 = 1; m_last = 0;
        end else if (w == 1) begin
            push_item(1, 0, 1, 0, 0, int'(bus.x1), int'(bus.y1), int'(bus.c1));
            m_g1 = 1; m_last = 1;
        end
    endtask

    task automatic drive(input bit rst, clr, r0, r1);
        reset         = rst;
        bus.clear_req = clr;
        bus.req0      = r0;
        bus.req1      = r1;
        bus.x0        = 8'($urandom_range(0, XW - 1));
        bus.x1        = 8'($urandom_range(0, XW - 1));
        bus.y0        = 7'($urandom_range(0, YH - 1));
        bus.y1        = 7'($urandom_range(0, YH - 1));
        bus.c0        = 3'($urandom);
        bus.c1        = 3'($urandom);
        step(rst, clr, r0, r1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " plot"}, int'(bus.plot), 0);
        chk({tag, " gnt0"}, int'(bus.gnt0), 0);
        chk({tag, " gnt1"}, int'(bus.gnt1), 0);
        chk({tag, " busy"}, int'(bus.clear_busy), 0);
        chk({tag, " done"}, int'(bus.clear_done), 0);
        chk({tag, " x"}, int'(bus.x), 0);
        chk({tag, " y"}, int'(bus.y), 0);
        chk({tag, " colour"}, int'(bus.colour), 0);
    endtask

    exp_t me;
    bit   pres;
    bit   bad;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_output: cycle %0d got nothing want plot=%0b done=%0b",
                     q[0].cyc, q[0].plot, q[0].done);
            void'(q.pop_front());
        end
        pres = bus.plot || bus.clear_done || bus.gnt0 || bus.gnt1 || bus.clear_busy;
        if (pres) begin
            vectors++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                miscompares++;
                $display("FAIL unexpected_output: cycle %0d got plot=%0b g=%0b%0b busy=%0b done=%0b want idle",
                         cyc, bus.plot, bus.gnt0, bus.gnt1, bus.clear_busy, bus.clear_done);
            end else begin
                me  = q.pop_front();
                bad = (bus.plot != me.plot) || (bus.gnt0 != me.g0) ||
                      (bus.gnt1 != me.g1) || (bus.clear_busy != me.busy) ||
                      (bus.clear_done != me.done);
                if (me.plot)
                    bad = bad || (bus.x != me.x) || (bus.y != me.y) ||
                          (bus.colour != me.c);
                if (bad) begin
                    miscompares++;
                    $display("FAIL write_port: cycle %0d got p=%0b g=%0b%0b b=%0b d=%0b (%0d,%0d,%0d) want p=%0b g=%0b%0b b=%0b d=%0b (%0d,%0d,%0d)",
                             cyc, bus.plot, bus.gnt0, bus.gnt1, bus.clear_busy,
                             bus.clear_done, bus.x, bus.y, bus.colour,
                             me.plot, me.g0, me.g1, me.busy, me.done,
                             me.x, me.y, me.c);
                end
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk_zero_outputs("reset");

        // single request with fixed pixel
        reset = 0; bus.clear_req = 0; bus.req0 = 1; bus.req1 = 0;
        bus.x0 = 8'd10; bus.y0 = 7'd20; bus.c0 = 3'b100;
        bus.x1 = 8'd0; bus.y1 = 7'd0; bus.c1 = 3'd0;
        step(0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("single x", int'(bus.x), 10);
        chk("single y", int'(bus.y), 20);
        chk("single colour", int'(bus.colour), 4);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // contention straight after reset
        drive(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);

        // random requests
        for (int i = 0; i < 300; i++)
            drive(0, 0, 1'($urandom), 1'($urandom));
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // clear wins over a request, req1 held, second clear ignored
        drive(0, 1, 1, 1);
        for (int i = 0; i < NPIX + 4; i++)
            drive(0, m_pos == 100, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // reset in the middle of a sweep
        drive(0, 1, 0, 0);
        for (int i = 0; i < NPIX && m_pos != 5000; i++) drive(0, 0, 0, 0);
        chk("sweep reached 5000", m_pos, 5000);
        drive(1, 0, 0, 0);
        chk_zero_outputs("mid-sweep reset");
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 50; i++)
            drive(0, 0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

        chk("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter X_MAX, default 159, last pixel column of the 160x120 frame.
REQ-002 Parameter Y_MAX, default 119, last pixel row.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000, colour written by the clear sweep.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear_req  input  1  one-cycle request to repaint the whole frame with CLEAR_COLOUR.
REQ-007 req0, req1  input  1 each  pixel write request from requester 0 (duck sprite) and requester 1 (HUD/shot flash).
REQ-008 x0, x1  input  8 each  requester pixel column.
REQ-009 y0, y1  input  7 each  requester pixel row.
REQ-010 c0, c1  input  3 each  requester pixel colour.
REQ-011 gnt0, gnt1  output  1 each  one-cycle grant, coincident with that requester's plot.
REQ-012 x  output  8  column to VGA adapter.
REQ-013 y  output  7  row to VGA adapter.
REQ-014 colour  output  3  colour to VGA adapter.
REQ-015 plot  output  1  write enable to VGA adapter.
REQ-016 clear_busy  output  1  high while the clear sweep owns the write port.
REQ-017 clear_done  output  1  one-cycle pulse when the sweep finishes.

Function
REQ-018 All outputs are registered; the arbiter is the only driver of the adapter's x/y/colour/plot.
REQ-019 States: IDLE (serve requesters), CLEAR (sweep), DONE (one cycle, pulse clear_done); after DONE, return to IDLE.
REQ-020 IDLE: requester k is eligible in cycle N when reqk=1 and gntk=0 in cycle N.
REQ-021 Grant latency: an eligible request sampled in cycle N produces plot=1, gntk=1, and x/y/colour = xk/yk/ck as sampled in N, all in cycle N+1.
REQ-022 At most one grant per cycle; gnt0 and gnt1 never high together; plot=1 exactly when a gnt or the sweep is writing.
REQ-023 Both eligible: round-robin; grant the requester not granted most recently; after reset, requester 0 wins the first tie.
REQ-024 One requester eligible: grant it regardless of pointer; the pointer updates to the granted requester.
REQ-025 A requester presents its next pixel in the cycle after its gnt; a requester held high continuously receives one grant every 2 cycles; two continuous requesters alternate, giving one plot per cycle.
REQ-026 No eligible requester: plot=0, gnt0=gnt1=0, and x/y/colour hold their last values.
REQ-027 clear_req in IDLE enters CLEAR next cycle; any requester grant already issued for that cycle completes; clear_req wins over a simultaneous request.
REQ-028 CLEAR: sweep x fastest from (0,0) to (X_MAX,Y_MAX), one pixel per cycle, plot=1, colour=CLEAR_COLOUR; 19200 consecutive plot cycles at default parameters.
REQ-029 clear_busy=1 from the first sweep plot through the last sweep plot; no grants issue while clear_busy=1; requests stay pending.
REQ-030 After the final pixel, state DONE: clear_done=1 for exactly one cycle, plot=0, no grant; IDLE arbitration resumes in the following cycle.
REQ-031 clear_req while in CLEAR or DONE is ignored (not queued).
REQ-032 Counter widths: x counter 8 bits, y counter 7 bits; x wraps to 0 and y increments at X_MAX; the sweep ends at (X_MAX,Y_MAX) with no wrap beyond it.

Reset
REQ-033 While reset=1 at a clock edge: state IDLE, plot=0, gnt0=gnt1=0, clear_busy=0, clear_done=0, x=0, y=0, colour=0, sweep counters 0, round-robin pointer = last-granted 1.
REQ-034 Reset asserted mid-sweep aborts the sweep without issuing clear_done; after release the block is in IDLE with no pending clear.

Verification
REQ-035 Single request: req0=1, x0=10, y0=20, c0=3'b100 in cycle 1 -> cycle 2 shows plot=1, gnt0=1, x=10, y=20, colour=3'b100; gnt1=0.
REQ-036 Contention after reset: req0=req1=1 held -> grants 0,1,0,1 on consecutive cycles, plot=1 every cycle, never both gnts high.
REQ-037 Clear: clear_req pulse at idle -> clear_busy high for 19200 cycles; first plot (0,0), (159,0) then (0,1), last plot (159,119) with colour 0; then a single clear_done pulse and clear_busy=0.
REQ-038 Request during clear: req1=1 held across the sweep -> no gnt1 while clear_busy=1; gnt1 occurs in the second cycle after clear_done.
REQ-039 Reset mid-sweep: reset=1 at sweep pixel 5000 -> next cycle all outputs 0, clear_done never pulses; a following req0 is granted with normal 1-cycle latency.
REQ-040 Ignored clear: second clear_req at sweep pixel 100 -> exactly one sweep of 19200 plots and one clear_done.
